// File: rtl/uart_gen_pkg.sv
// Shared types and constants for the uart_tx_gen transmitter.
// The BREAK state exists only when UART_TX_BREAK_EN is defined.
package uart_gen_pkg;

`ifdef UART_TX_BREAK_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_e;
    localparam int unsigned BRK_MIN_BITS = 13;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`endif

    localparam int unsigned DEF_DIV = 234;
    localparam int unsigned MIN_DIV = 2;

    // Bit times in one frame: start + data + optional parity + stop bits.
    function automatic logic [3:0] frame_bits(input logic data7, input logic par_en,
                                              input logic stop2);
        return 4'd1 + (data7 ? 4'd7 : 4'd8) + {3'b000, par_en} + (stop2 ? 4'd2 : 4'd1);
    endfunction

endpackage

// File: rtl/uart_gen_fifo.sv
// Synchronous byte FIFO; pointers carry one extra MSB so full and empty
// are distinguishable without a separate counter.
module uart_gen_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level_o = wr_ptr_q - rd_ptr_q;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i && !full_o) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i && !empty_o) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define
    // which entries are valid, and an unreset array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (push_i && !full_o) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/uart_tx_gen.sv
// UART transmitter with input byte FIFO and per-frame latched configuration.
// Define UART_TX_BREAK_EN to add the brk_req input and line-break generation.
module uart_tx_gen
    import uart_gen_pkg::*;
#(
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned DEF_DIV    = uart_gen_pkg::DEF_DIV
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DIV_W-1:0]              cfg_div,
    input  logic                          cfg_data7,
    input  logic                          cfg_par_en,
    input  logic                          cfg_par_odd,
    input  logic                          cfg_stop2,
`ifdef UART_TX_BREAK_EN
    input  logic                          brk_req,
`endif
    input  logic                          in_valid,
    input  logic [7:0]                    in_data,
    output logic                          in_ready,
    output logic                          txd,
    output logic                          busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             data7_q, data7_d;
    logic             par_en_q, par_en_d;
    logic             stop2_q, stop2_d;
    logic             parity_q, parity_d;
    logic             txd_q, txd_d;
    logic             tx_done_q, tx_done_d;
`ifdef UART_TX_BREAK_EN
    logic [3:0]       brk_bits_q, brk_bits_d;
    logic             brk_mark_q, brk_mark_d;
`endif

    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]       fifo_rdata, rdata_m;
    logic [DIV_W-1:0] cfg_div_eff;
    logic             bit_end, last_data, at_gap;

    assign fifo_push = in_valid && !fifo_full;

    uart_gen_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .wdata_i (in_data),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    assign cfg_div_eff = (cfg_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : cfg_div;
    assign rdata_m     = cfg_data7 ? {1'b0, fifo_rdata[6:0]} : fifo_rdata;
    assign bit_end     = (bit_cnt_q == div_q - DIV_W'(1));
    assign last_data   = (bit_idx_q == (data7_q ? 3'd6 : 3'd7));

    // NOTE: every always_comb output gets a default before the case so no
    // path leaves a signal unassigned and a latch is never inferred.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_cnt_d = bit_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data7_d   = data7_q;
        par_en_d  = par_en_q;
        stop2_d   = stop2_q;
        parity_d  = parity_q;
        txd_d     = txd_q;
        tx_done_d = 1'b0;
        fifo_pop  = 1'b0;
        at_gap    = 1'b0;
`ifdef UART_TX_BREAK_EN
        brk_bits_d = brk_bits_q;
        brk_mark_d = brk_mark_q;
`endif

        if (state_q != IDLE) bit_cnt_d = bit_end ? '0 : bit_cnt_q + DIV_W'(1);

        case (state_q)
            IDLE: at_gap = 1'b1;
            START: if (bit_end) begin
                state_d   = DATA;
                bit_idx_d = 3'd0;
                txd_d     = shift_q[0];
            end
            DATA: if (bit_end) begin
                if (last_data) begin
                    bit_idx_d = 3'd0;
                    state_d   = par_en_q ? PARITY : STOP;
                    txd_d     = par_en_q ? parity_q : 1'b1;
                end else begin
                    bit_idx_d = bit_idx_q + 3'd1;
                    shift_d   = shift_q >> 1;
                    txd_d     = shift_q[1];
                end
            end
            PARITY: if (bit_end) begin
                state_d = STOP;
                txd_d   = 1'b1;
            end
            STOP: if (bit_end) begin
                if (stop2_q && bit_idx_q == 3'd0) begin
                    bit_idx_d = 3'd1;
                end else begin
                    tx_done_d = 1'b1;
                    bit_idx_d = 3'd0;
                    state_d   = IDLE;
                    at_gap    = 1'b1;
                end
            end
`ifdef UART_TX_BREAK_EN
            BREAK: if (bit_end) begin
                if (brk_mark_q) begin
                    state_d = IDLE;
                end else begin
                    if (brk_bits_q != 4'(BRK_MIN_BITS)) brk_bits_d = brk_bits_q + 4'd1;
                    if ((brk_bits_q + 4'd1 >= 4'(BRK_MIN_BITS)) && !brk_req) begin
                        brk_mark_d = 1'b1;
                        txd_d      = 1'b1;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // Frame boundary: a new frame (or break) starts on this same edge.
        if (at_gap) begin
`ifdef UART_TX_BREAK_EN
            if (brk_req) begin
                state_d    = BREAK;
                txd_d      = 1'b0;
                bit_cnt_d  = '0;
                div_d      = cfg_div_eff;
                brk_bits_d = 4'd0;
                brk_mark_d = 1'b0;
            end else
`endif
            if (!fifo_empty) begin
                fifo_pop  = 1'b1;
                state_d   = START;
                txd_d     = 1'b0;
                bit_cnt_d = '0;
                div_d     = cfg_div_eff;
                data7_d   = cfg_data7;
                par_en_d  = cfg_par_en;
                stop2_d   = cfg_stop2;
                shift_d   = rdata_m;
                parity_d  = (^rdata_m) ^ cfg_par_odd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            div_q     <= DIV_W'(DEF_DIV);
            bit_cnt_q <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            data7_q   <= 1'b0;
            par_en_q  <= 1'b0;
            stop2_q   <= 1'b0;
            parity_q  <= 1'b0;
            txd_q     <= 1'b1;
            tx_done_q <= 1'b0;
`ifdef UART_TX_BREAK_EN
            brk_bits_q <= 4'd0;
            brk_mark_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_cnt_q <= bit_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data7_q   <= data7_d;
            par_en_q  <= par_en_d;
            stop2_q   <= stop2_d;
            parity_q  <= parity_d;
            txd_q     <= txd_d;
            tx_done_q <= tx_done_d;
`ifdef UART_TX_BREAK_EN
            brk_bits_q <= brk_bits_d;
            brk_mark_q <= brk_mark_d;
`endif
        end
    end

    assign txd      = txd_q;
    assign tx_done  = tx_done_q;
    assign busy     = (state_q != IDLE);
    assign in_ready = !fifo_full;

endmodule

// File: tb/tb_uart_tx_gen.sv
// Directed self-checking bench for uart_tx_gen; inputs driven and outputs
// sampled on the falling clock edge.
module tb_uart_tx_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cfg_div;
    logic        cfg_data7, cfg_par_en, cfg_par_odd, cfg_stop2;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready, txd, busy, tx_done;
    logic [3:0]  fifo_level;
`ifdef UART_TX_BREAK_EN
    logic        brk_req;
`endif

    int checks   = 0;
    int failures = 0;

    // Frame vectors, bit 0 = start bit; {stop, data, start} for 8N1.
    logic [7:0]  t2_bytes  [5] = '{8'h41, 8'h42, 8'h43, 8'h0D, 8'h0A};
    logic [11:0] t2_frames [5] = '{12'h282, 12'h284, 12'h286, 12'h21A, 12'h214};

    uart_tx_gen #(.DIV_W(16), .FIFO_DEPTH(8), .DEF_DIV(234)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_div     (cfg_div),
        .cfg_data7   (cfg_data7),
        .cfg_par_en  (cfg_par_en),
        .cfg_par_odd (cfg_par_odd),
        .cfg_stop2   (cfg_stop2),
`ifdef UART_TX_BREAK_EN
        .brk_req     (brk_req),
`endif
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .txd         (txd),
        .busy        (busy),
        .tx_done     (tx_done),
        .fifo_level  (fifo_level)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1, "simulation time limit exceeded");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_fall(input string tag, input int limit);
        int n = 0;
        while (txd !== 1'b0 && n < limit) begin
            step(1);
            n++;
        end
        check({tag, "_start_seen"}, txd, 0);
    endtask

    // Entered on the first low cycle of the start bit (minus 'skip' cycles);
    // returns on the cycle after the frame's last clock.
    task automatic check_frame(input string tag, input logic [11:0] bits, input int nbits,
                               input int d, input int skip);
        int bad;
        int idle  = 0;
        int early = 0;
        for (int i = 0; i < nbits; i++) begin
            bad = 0;
            for (int j = (i == 0) ? skip : 0; j < d; j++) begin
                if (txd !== bits[i]) bad++;
                if (busy !== 1'b1) idle++;
                if (!(i == 0 && j == 0) && tx_done !== 1'b0) early++;
                step(1);
            end
            check($sformatf("%s_bit%0d", tag, i), bad, 0);
        end
        check({tag, "_busy"}, idle, 0);
        check({tag, "_no_early_done"}, early, 0);
        check({tag, "_tx_done"}, tx_done, 1);
    endtask

    initial begin
        int accepted, n, errs, low, mark, dones;

        rst = 1'b1; cfg_div = 16'd234;
        cfg_data7 = 1'b0; cfg_par_en = 1'b0; cfg_par_odd = 1'b0; cfg_stop2 = 1'b0;
        in_valid = 1'b0; in_data = 8'h00;
`ifdef UART_TX_BREAK_EN
        brk_req = 1'b0;
`endif
        step(3);
        check("rst_txd", txd, 1);
        check("rst_busy", busy, 0);
        check("rst_tx_done", tx_done, 0);
        check("rst_level", fifo_level, 0);
        check("rst_ready", in_ready, 1);
        rst = 1'b0;
        step(1);

        // 8N1, D=234, single byte 0x41
        in_valid = 1'b1; in_data = 8'h41;
        check("t1_ready", in_ready, 1);
        step(1);
        in_valid = 1'b0;
        check("t1_level_pushed", fifo_level, 1);
        check("t1_txd_still_idle", txd, 1);
        step(1);
        check("t1_latency_txd_low", txd, 0);
        check("t1_busy", busy, 1);
        check("t1_level_popped", fifo_level, 0);
        check_frame("t1", 12'h282, 10, 234, 0);
        check("t1_idle_busy", busy, 0);
        check("t1_idle_txd", txd, 1);
        step(1);
        check("t1_done_one_cycle", tx_done, 0);

        // Five back-to-back 8N1 frames
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = t2_bytes[i];
            check($sformatf("t2_ready%0d", i), in_ready, 1);
            step(1);
        end
        in_valid = 1'b0;
        check("t2_level_push_pop", fifo_level, 4);
        for (int i = 0; i < 5; i++)
            check_frame($sformatf("t2_f%0d", i), t2_frames[i], 10, 234, (i == 0) ? 3 : 0);
        check("t2_idle_busy", busy, 0);

        // Fill the FIFO while a slow frame is on the line
        cfg_div = 16'd1000;
        accepted = 0;
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1; in_data = 8'h60 + 8'(i);
            if (in_ready === 1'b1) accepted++;
            step(1);
        end
        check("t3_accepted", accepted, 9);
        check("t3_level_full", fifo_level, 8);
        check("t3_ready_low", in_ready, 0);
        in_data = 8'h69;
        step(5);
        check("t3_hold_level", fifo_level, 8);
        check("t3_hold_ready", in_ready, 0);
        n = 0;
        while (in_ready !== 1'b1 && n < 12000) begin
            step(1);
            n++;
        end
        check("t3_ready_after_pop", in_ready, 1);
        check("t3_level_after_pop", fifo_level, 7);
        step(1);
        in_valid = 1'b0;
        check("t3_level_refill", fifo_level, 8);
        check("t3_ready_refill", in_ready, 0);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("t3_flush_level", fifo_level, 0);

        // 7E2, D=10: 0x35 then 0xB5 (bit 7 ignored) give identical frames
        cfg_div = 16'd10; cfg_data7 = 1'b1; cfg_par_en = 1'b1; cfg_par_odd = 1'b0;
        cfg_stop2 = 1'b1;
        in_valid = 1'b1; in_data = 8'h35;
        step(1);
        in_data = 8'hB5;
        step(1);
        in_valid = 1'b0;
        check_frame("t4_35", 12'h66A, 11, 10, 0);
        check_frame("t4_b5", 12'h66A, 11, 10, 0);
        check("t4_idle_busy", busy, 0);

        // 8O1, D=4, 0xFF; cfg altered mid-frame, then cfg_div=0 acts as D=2
        cfg_div = 16'd4; cfg_data7 = 1'b0; cfg_par_en = 1'b1; cfg_par_odd = 1'b1;
        cfg_stop2 = 1'b0;
        in_valid = 1'b1; in_data = 8'hFF;
        step(1);
        in_valid = 1'b0;
        step(1);
        cfg_div = 16'd0; cfg_par_en = 1'b0; cfg_par_odd = 1'b0;
        check_frame("t5_odd", 12'h7FE, 11, 4, 0);
        in_valid = 1'b1; in_data = 8'h55;
        step(1);
        in_valid = 1'b0;
        step(1);
        check_frame("t5_div0", 12'h2AA, 10, 2, 0);

        // Reset mid-DATA with three bytes queued
        cfg_div = 16'd10;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 8'h11 + 8'(i);
            step(1);
        end
        in_valid = 1'b0;
        step(40);
        check("t6_queued", fifo_level, 3);
        rst = 1'b1;
        step(1);
        check("t6_txd", txd, 1);
        check("t6_level", fifo_level, 0);
        check("t6_busy", busy, 0);
        check("t6_tx_done", tx_done, 0);
        check("t6_ready", in_ready, 1);
        rst = 1'b0;
        errs = 0;
        for (int i = 0; i < 300; i++) begin
            if (txd !== 1'b1 || tx_done !== 1'b0 || busy !== 1'b0) errs++;
            step(1);
        end
        check("t6_quiet_after_abort", errs, 0);

`ifdef UART_TX_BREAK_EN
        // Break held 20 bit times, D=10, then one mark bit
        brk_req = 1'b1;
        step(1);
        check("brk_busy", busy, 1);
        low = 0; dones = 0;
        for (int i = 0; i < 400; i++) begin
            if (txd !== 1'b0) break;
            if (tx_done !== 1'b0) dones++;
            low++;
            if (i == 195) brk_req = 1'b0;
            step(1);
        end
        check("brk_low_cycles", low, 200);
        mark = 0;
        while (txd === 1'b1 && busy === 1'b1 && mark < 100) begin
            if (tx_done !== 1'b0) dones++;
            mark++;
            step(1);
        end
        check("brk_mark_cycles", mark, 10);
        check("brk_idle", busy, 0);
        check("brk_no_done", dones, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
